// File: rtl/memory_stage.sv
// memory_stage: pipeline stage between execute and writeback.
// Issues data-memory requests for loads and stores and handles the grant and
// response handshake. Steers store bytes onto the correct lanes, and
// sign- or zero-extends load data. Holds upstream stages while an access is
// in flight and aborts a load whose response never arrives.
// Optional feature macro: MEM_STAGE_MISALIGN_EXC_EN
//   defined   -> misaligned H/W accesses are not issued and pulse 'misaligned'
//   undefined -> 'misaligned' is tied low and surplus low address bits are ignored
module memory_stage #(
   parameter int unsigned RESP_TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   input  logic [31:0] alu_res,
   input  logic [31:0] mem_data,
   input  logic        mem_read,
   input  logic        mem_write,
   input  logic [2:0]  mem_size,
   input  logic [4:0]  rd,
   input  logic        reg_write,
   output logic        stall,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [31:0] dmem_addr,
   output logic [31:0] dmem_wdata,
   output logic [3:0]  dmem_be,
   input  logic        dmem_gnt,
   input  logic        dmem_rvalid,
   input  logic [31:0] dmem_rdata,
   output logic        wb_valid,
   output logic [31:0] wb_data,
   output logic [4:0]  wb_rd,
   output logic        wb_reg_write,
   output logic        bus_err,
   output logic        misaligned
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_RESP = 2'd2
   } state_t;

   // The counter value on which a still-waiting RESP cycle gives up.
   localparam logic [7:0] TIMEOUT_LAST = 8'(RESP_TIMEOUT - 1);

   state_t      r_state;
   logic [7:0]  r_cnt;
   logic [31:0] r_addr;
   logic [2:0]  r_size;
   logic [4:0]  r_rd;
   logic        r_reg_write;
   logic        r_we;
   logic [31:0] r_wdata;
   logic [3:0]  r_be;
   logic        r_wb_valid;
   logic [31:0] r_wb_data;
   logic [4:0]  r_wb_rd;
   logic        r_wb_reg_write;
   logic        r_bus_err;
   logic        r_misaligned;

   logic        w_memop;
   logic        w_misalign;
   logic        w_start;
   logic        w_store_done;
   logic        w_timeout;
   logic [31:0] w_st_wdata;
   logic [3:0]  w_st_be;
   logic [31:0] w_shifted;
   logic [31:0] w_load_data;

   assign w_memop = in_valid & (mem_read | mem_write);

`ifdef MEM_STAGE_MISALIGN_EXC_EN
   // Halfwords need a[0]=0 and words need a[1:0]=0; stores use only size[1:0].
   assign w_misalign = w_memop &
                       (((mem_size[1:0] == 2'b01) & alu_res[0]) |
                        ((mem_size[1:0] == 2'b10) & (alu_res[1:0] != 2'b00)));
`else
   assign w_misalign = 1'b0;
`endif

   assign w_start      = (r_state == S_IDLE) & w_memop & ~w_misalign;
   assign w_store_done = (r_state == S_REQ) & r_we & dmem_gnt;
   assign w_timeout    = (r_state == S_RESP) & ~dmem_rvalid & (r_cnt == TIMEOUT_LAST);

   // Stall is forced low while reset is asserted, so upstream sees a quiet stage.
   assign stall = rst & (w_start |
                         ((r_state == S_REQ) & ~w_store_done) |
                         ((r_state == S_RESP) & ~dmem_rvalid & ~w_timeout));

   assign dmem_req     = (r_state == S_REQ);
   assign dmem_we      = r_we;
   assign dmem_addr    = {r_addr[31:2], 2'b00};
   assign dmem_wdata   = r_wdata;
   assign dmem_be      = r_be;
   assign wb_valid     = r_wb_valid;
   assign wb_data      = r_wb_data;
   assign wb_rd        = r_wb_rd;
   assign wb_reg_write = r_wb_reg_write;
   assign bus_err      = r_bus_err;
   assign misaligned   = r_misaligned;

   // Replicate store data across lanes and pick byte enables from the low address bits.
   always_comb begin
      w_st_wdata = mem_data;
      w_st_be    = 4'b1111;
      case (mem_size[1:0])
         2'b00: begin
            w_st_wdata = {4{mem_data[7:0]}};
            w_st_be    = 4'b0001 << alu_res[1:0];
         end
         2'b01: begin
            w_st_wdata = {2{mem_data[15:0]}};
            w_st_be    = alu_res[1] ? 4'b1100 : 4'b0011;
         end
         default: begin
            w_st_wdata = mem_data;
            w_st_be    = 4'b1111;
         end
      endcase
   end

   // Bring the addressed byte or halfword down to bit 0, then extend it.
   always_comb begin
      w_shifted = dmem_rdata;
      case (r_size[1:0])
         2'b00:   w_shifted = dmem_rdata >> {r_addr[1:0], 3'b000};
         2'b01:   w_shifted = dmem_rdata >> {r_addr[1], 4'b0000};
         default: w_shifted = dmem_rdata;
      endcase
      w_load_data = w_shifted;
      case (r_size)
         3'b000:  w_load_data = {{24{w_shifted[7]}}, w_shifted[7:0]};
         3'b100:  w_load_data = {24'd0, w_shifted[7:0]};
         3'b001:  w_load_data = {{16{w_shifted[15]}}, w_shifted[15:0]};
         3'b101:  w_load_data = {16'd0, w_shifted[15:0]};
         default: w_load_data = w_shifted;
      endcase
   end

   // Access FSM plus the registered writeback slot and status pulses.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state        <= S_IDLE;
         r_cnt          <= 8'd0;
         r_addr         <= 32'd0;
         r_size         <= 3'd0;
         r_rd           <= 5'd0;
         r_reg_write    <= 1'b0;
         r_we           <= 1'b0;
         r_wdata        <= 32'd0;
         r_be           <= 4'd0;
         r_wb_valid     <= 1'b0;
         r_wb_data      <= 32'd0;
         r_wb_rd        <= 5'd0;
         r_wb_reg_write <= 1'b0;
         r_bus_err      <= 1'b0;
         r_misaligned   <= 1'b0;
      end else begin
         r_wb_valid     <= 1'b0;
         r_wb_reg_write <= 1'b0;
         r_bus_err      <= 1'b0;
         r_misaligned   <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_misalign) begin
                  r_misaligned   <= 1'b1;
                  r_wb_valid     <= 1'b1;
                  r_wb_data      <= alu_res;
                  r_wb_rd        <= rd;
                  r_wb_reg_write <= 1'b0;
               end else if (w_memop) begin
                  r_state     <= S_REQ;
                  r_addr      <= alu_res;
                  r_size      <= mem_size;
                  r_rd        <= rd;
                  r_reg_write <= reg_write;
                  r_we        <= mem_write & ~mem_read;
                  r_wdata     <= w_st_wdata;
                  r_be        <= (mem_write & ~mem_read) ? w_st_be : 4'b1111;
               end else if (in_valid) begin
                  r_wb_valid     <= 1'b1;
                  r_wb_data      <= alu_res;
                  r_wb_rd        <= rd;
                  r_wb_reg_write <= reg_write;
               end
            end
            S_REQ: begin
               if (dmem_gnt) begin
                  if (r_we) begin
                     r_state        <= S_IDLE;
                     r_wb_valid     <= 1'b1;
                     r_wb_data      <= 32'd0;
                     r_wb_rd        <= r_rd;
                     r_wb_reg_write <= 1'b0;
                  end else begin
                     r_state <= S_RESP;
                     r_cnt   <= 8'd0;
                  end
               end
            end
            S_RESP: begin
               if (dmem_rvalid) begin
                  r_state        <= S_IDLE;
                  r_wb_valid     <= 1'b1;
                  r_wb_data      <= w_load_data;
                  r_wb_rd        <= r_rd;
                  r_wb_reg_write <= r_reg_write;
               end else if (r_cnt == TIMEOUT_LAST) begin
                  r_state        <= S_IDLE;
                  r_bus_err      <= 1'b1;
                  r_wb_valid     <= 1'b1;
                  r_wb_data      <= 32'd0;
                  r_wb_rd        <= r_rd;
                  r_wb_reg_write <= 1'b0;
               end else begin
                  r_cnt <= r_cnt + 8'd1;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_memory_stage.sv
// tb_memory_stage: directed checks of memory_stage covering stores, loads,
// timeout abort, pass-through, asynchronous reset and misaligned halfwords.
module tb_memory_stage;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic [31:0] alu_res = 32'd0;
   logic [31:0] mem_data = 32'd0;
   logic        mem_read = 1'b0;
   logic        mem_write = 1'b0;
   logic [2:0]  mem_size = 3'd0;
   logic [4:0]  rd = 5'd0;
   logic        reg_write = 1'b0;
   logic        dmem_gnt = 1'b0;
   logic        dmem_rvalid = 1'b0;
   logic [31:0] dmem_rdata = 32'd0;
   logic        stall;
   logic        dmem_req;
   logic        dmem_we;
   logic [31:0] dmem_addr;
   logic [31:0] dmem_wdata;
   logic [3:0]  dmem_be;
   logic        wb_valid;
   logic [31:0] wb_data;
   logic [4:0]  wb_rd;
   logic        wb_reg_write;
   logic        bus_err;
   logic        misaligned;

   int total = 0;
   int bad = 0;

   memory_stage #(.RESP_TIMEOUT(16)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .alu_res(alu_res),
      .mem_data(mem_data), .mem_read(mem_read), .mem_write(mem_write),
      .mem_size(mem_size), .rd(rd), .reg_write(reg_write), .stall(stall),
      .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
      .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .dmem_gnt(dmem_gnt),
      .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata), .wb_valid(wb_valid),
      .wb_data(wb_data), .wb_rd(wb_rd), .wb_reg_write(wb_reg_write),
      .bus_err(bus_err), .misaligned(misaligned)
   );

   // 10 ns clock; inputs change on the falling edge, checks follow 1 ns later.
   always #5 clk = ~clk;

   // Safety net so the run can never hang.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   task automatic applyStimulus(input logic v, input logic [31:0] a, input logic [31:0] d,
                                input logic rdn, input logic wr, input logic [2:0] sz,
                                input logic [4:0] dst, input logic rw);
      in_valid  = v;
      alu_res   = a;
      mem_data  = d;
      mem_read  = rdn;
      mem_write = wr;
      mem_size  = sz;
      rd        = dst;
      reg_write = rw;
   endtask

   task automatic applyBus(input logic g, input logic rv, input logic [31:0] rdat);
      dmem_gnt    = g;
      dmem_rvalid = rv;
      dmem_rdata  = rdat;
   endtask

   task automatic nextCycle();
      @(negedge clk);
   endtask

   // LB/LBU at 0x2001: grant on the third REQ cycle, data one cycle after.
   task automatic byteLoad(input string tag, input logic [2:0] sz, input logic [31:0] exp);
      nextCycle(); applyStimulus(1, 32'h2001, 0, 1, 0, sz, 5'd3, 1); applyBus(0, 0, 0); #1;
      checkOutput({tag, "_stall_idle"}, stall, 1);
      nextCycle(); #1;
      checkOutput({tag, "_stall_req1"}, stall, 1);
      checkOutput({tag, "_addr"}, dmem_addr, 32'h2000);
      nextCycle(); #1;
      checkOutput({tag, "_stall_req2"}, stall, 1);
      nextCycle(); applyBus(1, 0, 0); #1;
      checkOutput({tag, "_req_gnt"}, dmem_req, 1);
      checkOutput({tag, "_stall_gnt"}, stall, 1);
      nextCycle(); applyBus(0, 0, 0); #1;
      checkOutput({tag, "_stall_resp"}, stall, 1);
      checkOutput({tag, "_req_resp"}, dmem_req, 0);
      nextCycle(); applyBus(0, 1, 32'h0000_8000); #1;
      checkOutput({tag, "_stall_rvalid"}, stall, 0);
      nextCycle(); applyStimulus(0, 0, 0, 0, 0, 0, 0, 0); applyBus(0, 0, 0); #1;
      checkOutput({tag, "_wb_valid"}, wb_valid, 1);
      checkOutput({tag, "_wb_data"}, wb_data, exp);
      checkOutput({tag, "_wb_rd"}, wb_rd, 5'd3);
      checkOutput({tag, "_wb_rw"}, wb_reg_write, 1);
   endtask

   // Directed sequence of all scenarios.
   initial begin
      #2 rst = 1'b0;
      nextCycle(); #1;
      checkOutput("rst_req", dmem_req, 0);
      checkOutput("rst_stall", stall, 0);
      checkOutput("rst_wb_valid", wb_valid, 0);
      checkOutput("rst_bus_err", bus_err, 0);
      checkOutput("rst_misaligned", misaligned, 0);
      rst = 1'b1;

      // SB 0x12345678 to 0x1003, granted in first REQ cycle.
      nextCycle(); applyStimulus(1, 32'h1003, 32'h1234_5678, 0, 1, 3'b000, 5'd0, 0); #1;
      checkOutput("sb_stall_idle", stall, 1);
      checkOutput("sb_req_idle", dmem_req, 0);
      nextCycle(); applyBus(1, 0, 0); #1;
      checkOutput("sb_req", dmem_req, 1);
      checkOutput("sb_we", dmem_we, 1);
      checkOutput("sb_addr", dmem_addr, 32'h1000);
      checkOutput("sb_be", dmem_be, 4'b1000);
      checkOutput("sb_wdata", dmem_wdata, 32'h7878_7878);
      checkOutput("sb_stall_gnt", stall, 0);
      nextCycle(); applyStimulus(0, 0, 0, 0, 0, 0, 0, 0); applyBus(0, 0, 0); #1;
      checkOutput("sb_wb_valid", wb_valid, 1);
      checkOutput("sb_wb_rw", wb_reg_write, 0);
      checkOutput("sb_req_after", dmem_req, 0);

      // SH to 0x0012 with a one-cycle grant delay.
      nextCycle(); applyStimulus(1, 32'h0012, 32'hAAAA_5678, 0, 1, 3'b001, 5'd0, 0); #1;
      checkOutput("sh_stall_idle", stall, 1);
      nextCycle(); #1;
      checkOutput("sh_stall_wait", stall, 1);
      checkOutput("sh_be", dmem_be, 4'b1100);
      checkOutput("sh_wdata", dmem_wdata, 32'h5678_5678);
      nextCycle(); applyBus(1, 0, 0); #1;
      checkOutput("sh_stall_gnt", stall, 0);
      nextCycle(); applyStimulus(0, 0, 0, 0, 0, 0, 0, 0); applyBus(0, 0, 0); #1;
      checkOutput("sh_wb_valid", wb_valid, 1);
      checkOutput("sh_wb_rw", wb_reg_write, 0);

      // ADD pass-through immediately followed by LW.
      nextCycle(); applyStimulus(1, 32'hDEAD_BEEF, 0, 0, 0, 3'b000, 5'd5, 1); #1;
      checkOutput("add_stall", stall, 0);
      nextCycle(); applyStimulus(1, 32'h4000, 0, 1, 0, 3'b010, 5'd7, 1); #1;
      checkOutput("add_wb_valid", wb_valid, 1);
      checkOutput("add_wb_data", wb_data, 32'hDEAD_BEEF);
      checkOutput("add_wb_rd", wb_rd, 5'd5);
      checkOutput("add_wb_rw", wb_reg_write, 1);
      checkOutput("lw_stall_idle", stall, 1);
      nextCycle(); applyBus(1, 0, 0); #1;
      checkOutput("lw_stall_req", stall, 1);
      checkOutput("lw_req", dmem_req, 1);
      checkOutput("lw_we", dmem_we, 0);
      checkOutput("lw_addr", dmem_addr, 32'h4000);
      checkOutput("lw_wb_valid_req", wb_valid, 0);
      nextCycle(); applyBus(0, 1, 32'hCAFE_F00D); #1;
      checkOutput("lw_stall_rvalid", stall, 0);
      checkOutput("lw_req_resp", dmem_req, 0);
      nextCycle(); applyStimulus(0, 0, 0, 0, 0, 0, 0, 0); applyBus(0, 0, 0); #1;
      checkOutput("lw_wb_valid", wb_valid, 1);
      checkOutput("lw_wb_data", wb_data, 32'hCAFE_F00D);
      checkOutput("lw_wb_rd", wb_rd, 5'd7);
      checkOutput("lw_wb_rw", wb_reg_write, 1);

      // LB then LBU of byte 1 from 0x00008000.
      byteLoad("lb", 3'b000, 32'hFFFF_FF80);
      byteLoad("lbu", 3'b100, 32'h0000_0080);

      // LW whose response never arrives within 16 RESP cycles.
      nextCycle(); applyStimulus(1, 32'h5000, 0, 1, 0, 3'b010, 5'd9, 1); #1;
      checkOutput("to_stall_idle", stall, 1);
      nextCycle(); applyBus(1, 0, 0); #1;
      checkOutput("to_req", dmem_req, 1);
      for (int k = 0; k < 16; k++) begin
         nextCycle(); applyBus(0, 0, 0); #1;
         checkOutput($sformatf("to_stall_wait%0d", k), stall, (k == 15) ? 32'd0 : 32'd1);
      end
      nextCycle(); applyStimulus(0, 0, 0, 0, 0, 0, 0, 0); applyBus(0, 1, 32'h1111_1111); #1;
      checkOutput("to_bus_err", bus_err, 1);
      checkOutput("to_wb_valid", wb_valid, 1);
      checkOutput("to_wb_rw", wb_reg_write, 0);
      checkOutput("to_req_after", dmem_req, 0);
      checkOutput("to_stall_after", stall, 0);
      nextCycle(); applyBus(0, 0, 0); #1;
      checkOutput("to_bus_err_clear", bus_err, 0);
      checkOutput("to_late_ignored", wb_valid, 0);

      // Asynchronous reset while waiting in RESP.
      nextCycle(); applyStimulus(1, 32'h6000, 0, 1, 0, 3'b010, 5'd4, 1); #1;
      checkOutput("rr_stall_idle", stall, 1);
      nextCycle(); applyBus(1, 0, 0); #1;
      nextCycle(); applyBus(0, 0, 0); #1;
      checkOutput("rr_stall_resp", stall, 1);
      rst = 1'b0; #1;
      checkOutput("rr_req", dmem_req, 0);
      checkOutput("rr_stall", stall, 0);
      checkOutput("rr_wb_valid", wb_valid, 0);
      checkOutput("rr_wb_data", wb_data, 0);
      checkOutput("rr_wb_rd", wb_rd, 0);
      checkOutput("rr_wb_rw", wb_reg_write, 0);
      checkOutput("rr_addr", dmem_addr, 0);
      nextCycle(); applyStimulus(0, 0, 0, 0, 0, 0, 0, 0); rst = 1'b1;

      // LH at 0x3001 after reset.
      nextCycle(); applyStimulus(1, 32'h3001, 0, 1, 0, 3'b001, 5'd6, 1); applyBus(0, 0, 0); #1;
`ifdef MEM_STAGE_MISALIGN_EXC_EN
      checkOutput("lh_stall", stall, 0);
      nextCycle(); applyStimulus(0, 0, 0, 0, 0, 0, 0, 0); #1;
      checkOutput("lh_misaligned", misaligned, 1);
      checkOutput("lh_wb_valid", wb_valid, 1);
      checkOutput("lh_wb_rw", wb_reg_write, 0);
      checkOutput("lh_req", dmem_req, 0);
      nextCycle(); #1;
      checkOutput("lh_misaligned_clear", misaligned, 0);
`else
      checkOutput("lh_stall", stall, 1);
      nextCycle(); applyBus(1, 0, 0); #1;
      checkOutput("lh_req", dmem_req, 1);
      checkOutput("lh_addr", dmem_addr, 32'h3000);
      nextCycle(); applyBus(0, 1, 32'h1234_8765); #1;
      checkOutput("lh_stall_rvalid", stall, 0);
      nextCycle(); applyStimulus(0, 0, 0, 0, 0, 0, 0, 0); applyBus(0, 0, 0); #1;
      checkOutput("lh_wb_data", wb_data, 32'hFFFF_8765);
      checkOutput("lh_wb_rd", wb_rd, 5'd6);
      checkOutput("lh_wb_rw", wb_reg_write, 1);
      checkOutput("lh_misaligned", misaligned, 0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/memory_stage.md
Name: memory_stage

Overview:
- Pipeline stage directly downstream of execute: consumes ALU result (address or result), store data and memory control; drives data-memory request/grant/response handshake; registers result toward writeback.
- Handles byte/half/word lane steering, load sign/zero extension, pipeline stall during memory access, and response timeout.

Parameters:
- RESP_TIMEOUT, 16, max cycles waiting in RESP for dmem_rvalid before abort (range 1..255)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- in_valid  in  1  execute output holds a valid instruction
- alu_res  in  32  ALU result; effective address for loads/stores
- mem_data  in  32  store data (forwarded rs2)
- mem_read  in  1  instruction is a load
- mem_write  in  1  instruction is a store
- mem_size  in  3  funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU (stores use [1:0])
- rd  in  5  destination register
- reg_write  in  1  instruction writes rd
- stall  out  1  hold upstream stages; in_* must stay stable while high
- dmem_req  out  1  memory request
- dmem_we  out  1  1 = write
- dmem_addr  out  32  word address ({alu_res[31:2],2'b00})
- dmem_wdata  out  32  lane-replicated store data
- dmem_be  out  4  byte enables
- dmem_gnt  in  1  request accepted this cycle
- dmem_rvalid  in  1  read data valid (never same cycle as gnt)
- dmem_rdata  in  32  read data
- wb_valid  out  1  writeback slot valid
- wb_data  out  32  writeback value
- wb_rd  out  5  writeback register
- wb_reg_write  out  1  writeback enable
- bus_err  out  1  one-cycle pulse on response timeout
- misaligned  out  1  one-cycle pulse on misaligned access (macro-dependent)

Behaviour:
- Reset (rst=0, async): state IDLE, timeout counter 0, all outputs 0; in-flight access abandoned, dmem_req drops immediately.
- FSM IDLE/REQ/RESP. IDLE + in_valid + (mem_read|mem_write): latch address, size, rd, wdata/be -> REQ. mem_read and mem_write both set: treated as load.
- REQ: dmem_req=1, addr/we/wdata/be stable until dmem_gnt. Store + gnt -> IDLE, wb_valid=1, wb_reg_write=0 next cycle. Load + gnt -> RESP, counter cleared.
- RESP: dmem_rvalid -> IDLE, wb_data = extracted load, wb_reg_write = latched reg_write, next cycle. Counter increments per waiting cycle; reaching RESP_TIMEOUT -> IDLE, bus_err pulse, wb_valid=1 with wb_reg_write=0; late rvalid after abort ignored.
- stall = (IDLE & in_valid & memop) | REQ | (RESP & !dmem_rvalid & !timeout) ; in REQ for a store, stall is low in the gnt cycle. Upstream advances on the edge where stall is low.
- Non-memory instruction: 1-cycle registered pass-through, wb_data=alu_res, no stall. in_valid=0 -> wb_valid=0 next cycle.
- Store lanes: B: wdata={4{d[7:0]}}, be=0001<<a[1:0]; H: wdata={2{d[15:0]}}, be=0011<<(2*a[1]); W: be=1111.
- Load extract: byte = rdata>>(8*a[1:0]); B/H sign-extend, BU/HU zero-extend, W unchanged.
- Best-case latency: store 2 cycles accept-to-wb (gnt first REQ cycle), load 3 cycles.

Optional Feature:
- MEM_STAGE_MISALIGN_EXC_EN defined: H with a[0]=1 or W with a[1:0]!=0 -> no dmem request, misaligned pulses one cycle, wb_valid=1, wb_reg_write=0, no stall.
- Undefined: misaligned tied 0; low address bits beyond natural alignment ignored (H uses a[1], W ignores a[1:0]); access proceeds.

Test Plan:
- SB mem_data=0x12345678 addr=0x1003, gnt same cycle -> dmem_be=1000, dmem_wdata=0x78787878, wb_reg_write=0, stall 1 cycle.
- LB addr=0x2001, gnt after 2 cycles, rdata=0x0000_8000 after 1 more -> wb_data=0xFFFFFF80; LBU same -> 0x00000080; stall high until rvalid cycle.
- LW with no rvalid for RESP_TIMEOUT=16 cycles -> bus_err pulse, wb_reg_write=0, state IDLE; rvalid arriving later ignored.
- ADD result 0xDEADBEEF rd=5 back-to-back with LW -> pass-through wb next cycle, no stall; LW then stalls correctly.
- rst low while in RESP -> dmem_req, stall, wb_* all 0 immediately; next load after reset completes normally.
- LH addr=0x3001: with MEM_STAGE_MISALIGN_EXC_EN -> misaligned pulse, no dmem_req; without -> request to 0x3000, low half extracted.
